psum_drain: RTL and testbench
=============================

PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 Parameter X_DIM, default 15: number of PE-array row outputs captured per transfer.
REQ-002 Parameter DATA_WIDTH, default 8: width of the drained output word; input partial sums are 2*DATA_WIDTH.
REQ-003 Parameter ACC_WIDTH, default 24: signed accumulator width per lane.
REQ-004 Parameter SHIFT, default 4: arithmetic right shift applied before output saturation.
REQ-005 clk  in  1: single clock, rising edge.
REQ-006 rst  in  1: asynchronous, active-high reset.
REQ-007 cap_valid  in  1: a psum vector is presented on pe_out.
REQ-008 cap_ready  out  1: block can accept a capture.
REQ-009 pe_out  in  X_DIM x 2*DATA_WIDTH: signed partial sums, one per row, from the PE array's registered output.
REQ-010 acc_mode  in  1: 0 = overwrite lane, 1 = add to lane; sampled with capture.
REQ-011 last_pass  in  1: this capture completes the tile and triggers the drain; sampled with capture.
REQ-012 out_valid  out  1: out_data/out_idx are valid.
REQ-013 out_ready  in  1: downstream accepts the word.
REQ-014 out_data  out  DATA_WIDTH: signed, saturated, post-shift result.
REQ-015 out_idx  out  $clog2(X_DIM): lane index of out_data.
REQ-016 busy  out  1: high in ACCUM or DRAIN.
REQ-017 ovf_flag  out  1: sticky, set if any lane accumulation wrapped.

Function
REQ-018 The FSM SHALL have states IDLE, ACCUM and DRAIN.
REQ-019 cap_ready SHALL be 1 in IDLE and ACCUM and 0 in DRAIN.
REQ-020 On the cap_valid&&cap_ready edge, each lane SHALL load sign_extend(pe_out[i]) if acc_mode=0, else lane+sign_extend(pe_out[i]) modulo 2^ACC_WIDTH.
REQ-021 On a capture, the next state SHALL be DRAIN if last_pass=1, else ACCUM.
REQ-022 acc_mode=1 in IDLE SHALL be treated as acc_mode=0 (no stale accumulation).
REQ-023 ovf_flag SHALL set on any lane signed overflow during an add and clear on an overwrite capture that has no overflow.
REQ-024 In DRAIN, out_valid SHALL be 1 starting the first cycle after the last_pass capture; out_idx SHALL start at 0.
REQ-025 out_data SHALL equal lane[out_idx]>>>SHIFT saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-026 While out_valid&&!out_ready, out_data and out_idx SHALL hold stable.
REQ-027 On each out_valid&&out_ready, out_idx SHALL increment; on the handshake at idx X_DIM-1 the FSM SHALL go to IDLE with out_valid=0 the next cycle.
REQ-028 Throughput SHALL be one word per cycle when out_ready is held high; drain of X_DIM lanes takes X_DIM cycles.
REQ-029 cap_valid during DRAIN SHALL be ignored and lanes unchanged.
REQ-030 A capture in IDLE with last_pass=1 SHALL drain directly (single-pass tile).

Reset
REQ-031 rst SHALL asynchronously force state IDLE, all lanes 0, out_idx 0, out_valid 0, busy 0, ovf_flag 0, cap_ready 1 (out_data thus 0).
REQ-032 rst asserted mid-DRAIN SHALL abort the drain with no further out_valid after release until a new last_pass capture.

Configuration
REQ-033 Macro PSUM_DRAIN_RELU_EN defined: out_data SHALL be 0 for any negative post-shift value (ReLU before saturation).
REQ-034 Macro PSUM_DRAIN_RELU_EN undefined: negative values SHALL pass through signed saturation unchanged.

Verification
REQ-035 Single pass: pe_out[i]=16*i, acc_mode=0, last_pass=1, out_ready=1 -> out_data=i for idx 0..14 on 15 consecutive cycles, then IDLE.
REQ-036 Three passes of pe_out[i]=100 (acc_mode 0,1,1; last on third) -> every lane 300>>>4=18.
REQ-037 pe_out[0]=32767 accumulated 300 times -> ovf_flag=1; lane 0 output per wrapped value; other lanes with 4095 -> 127 saturated.
REQ-038 pe_out[3]=-320, single pass -> out_data[3]=-20 without macro, 0 with PSUM_DRAIN_RELU_EN.
REQ-039 out_ready toggling 1,0,0,1 during drain, cap_valid=1 throughout -> no word skipped or duplicated, values held while stalled, cap_ready=0, lanes unchanged.
REQ-040 rst pulsed at idx 7 of a drain -> out_valid=0 immediately, busy=0, next single-pass capture drains from idx 0 with new data.

Source files
------------

// File: rtl/psum_drain_if.sv
// psum_drain_if: capture and drain bundle for psum_drain.
//   slave  modport: used by psum_drain (accepts captures, produces drain words)
//   master modport: used by the producer/consumer side
// Ports carried:
//   cap_valid/cap_ready : capture handshake, pe_out/acc_mode/last_pass qualified by it
//   out_valid/out_ready : drain handshake, out_data/out_idx qualified by it
//   busy, ovf_flag      : status
interface psum_drain_if #(
  parameter int X_DIM      = 15,
  parameter int DATA_WIDTH = 8
);
  localparam int IDX_W = (X_DIM > 1) ? $clog2(X_DIM) : 1;

  logic                                 cap_valid;
  logic                                 cap_ready;
  logic [X_DIM-1:0][2*DATA_WIDTH-1:0]   pe_out;
  logic                                 acc_mode;
  logic                                 last_pass;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [DATA_WIDTH-1:0]                out_data;
  logic [IDX_W-1:0]                     out_idx;
  logic                                 busy;
  logic                                 ovf_flag;

  modport master (
    output cap_valid, pe_out, acc_mode, last_pass, out_ready,
    input  cap_ready, out_valid, out_data, out_idx, busy, ovf_flag
  );

  modport slave (
    input  cap_valid, pe_out, acc_mode, last_pass, out_ready,
    output cap_ready, out_valid, out_data, out_idx, busy, ovf_flag
  );
endinterface

// File: rtl/psum_drain.sv
// psum_drain: captures PE-array partial-sum vectors into per-lane signed
// accumulators (overwrite or add), then drains the lanes one word per cycle
// as shifted, saturated DATA_WIDTH values.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : psum_drain_if.slave (capture handshake, drain handshake, status)
// Build option:
//   PSUM_DRAIN_RELU_EN defined -> negative post-shift values drain as 0.
//
// state | meaning
// IDLE  | no tile in progress; a capture always overwrites the lanes
// ACCUM | tile in progress; captures overwrite or add per acc_mode
// DRAIN | lanes streamed out at out_idx; captures refused
module psum_drain #(
  parameter int X_DIM      = 15,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int SHIFT      = 4
) (
  input  logic       clk,
  input  logic       rst,
  psum_drain_if.slave bus
);
  localparam int IDX_W = (X_DIM > 1) ? $clog2(X_DIM) : 1;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - ACC_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  lanes    [X_DIM];
  logic signed [ACC_WIDTH-1:0]  lane_nxt [X_DIM];
  logic signed [ACC_WIDTH-1:0]  ext      [X_DIM];
  logic signed [ACC_WIDTH-1:0]  sum      [X_DIM];
  logic [X_DIM-1:0]             lane_ovf;
  logic [IDX_W-1:0]             idx_q;
  logic                         ovf_q;
  logic                         cap_fire;
  logic                         out_fire;
  logic                         do_add;
  logic                         last_word;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic signed [ACC_WIDTH-1:0]  clipped;

  assign cap_fire  = bus.cap_valid && (state_q != DRAIN);
  assign out_fire  = bus.out_ready && (state_q == DRAIN);
  assign last_word = (idx_q == IDX_W'(X_DIM - 1));
  // Adding only from ACCUM keeps stale lanes from a finished tile out of a new one.
  assign do_add    = bus.acc_mode && (state_q == ACCUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.cap_ready = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cap_ready = 1'b1;
        if (bus.cap_valid) state_d = bus.last_pass ? DRAIN : ACCUM;
      end
      ACCUM: begin
        bus.cap_ready = 1'b1;
        bus.busy      = 1'b1;
        if (bus.cap_valid) state_d = bus.last_pass ? DRAIN : ACCUM;
      end
      DRAIN: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        if (bus.out_ready && last_word) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Signed overflow: operands share a sign and the sum's sign differs.
  always_comb begin
    lane_ovf = '0;
    for (int i = 0; i < X_DIM; i++) begin
      ext[i]      = {{(ACC_WIDTH - PW){bus.pe_out[i][PW-1]}}, bus.pe_out[i]};
      sum[i]      = lanes[i] + ext[i];
      lane_ovf[i] = do_add && (lanes[i][ACC_WIDTH-1] == ext[i][ACC_WIDTH-1])
                    && (sum[i][ACC_WIDTH-1] != lanes[i][ACC_WIDTH-1]);
      lane_nxt[i] = do_add ? sum[i] : ext[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < X_DIM; i++) lanes[i] <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (cap_fire) begin
        for (int i = 0; i < X_DIM; i++) lanes[i] <= lane_nxt[i];
        ovf_q <= do_add ? (ovf_q | (|lane_ovf)) : 1'b0;
      end
      if (out_fire) idx_q <= last_word ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Output word is combinational from the held index, so it stays stable under backpressure.
  always_comb begin
    shifted = lanes[idx_q] >>> SHIFT;
`ifdef PSUM_DRAIN_RELU_EN
    if (shifted < 0) shifted = '0;
`endif
    if (shifted > SAT_MAX)      clipped = SAT_MAX;
    else if (shifted < SAT_MIN) clipped = SAT_MIN;
    else                        clipped = shifted;
  end

  assign bus.out_data = clipped[DATA_WIDTH-1:0];
  assign bus.out_idx  = idx_q;
  assign bus.ovf_flag = ovf_q;
endmodule

// File: tb/tb_psum_drain.sv
module tb_psum_drain;
  localparam int X  = 15;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psum_drain_if #(.X_DIM(X), .DATA_WIDTH(DW)) bus ();

  psum_drain #(.X_DIM(X), .DATA_WIDTH(DW), .ACC_WIDTH(24), .SHIFT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic signed [15:0] pe_v [X];
  int exp_out  [X];
  int obs_idx  [40];
  int obs_data [40];
  int n_words;
  logic end_busy, end_crdy, end_valid;

  task automatic set_pe();
    for (int i = 0; i < X; i++) bus.pe_out[i] = pe_v[i];
  endtask

  // Called at a negedge; the capture lands on the next posedge.
  task automatic capture(input logic acc, input logic last);
    set_pe();
    bus.cap_valid = 1'b1;
    bus.acc_mode  = acc;
    bus.last_pass = last;
    @(negedge clk);
    bus.cap_valid = 1'b0;
    bus.acc_mode  = 1'b0;
    bus.last_pass = 1'b0;
  endtask

  // Records words with out_ready held high until out_valid drops.
  task automatic run_drain();
    int cyc = 0;
    n_words = 0;
    bus.out_ready = 1'b1;
    while (bus.out_valid === 1'b1 && cyc < 40) begin
      obs_idx[n_words]  = int'(bus.out_idx);
      obs_data[n_words] = int'($signed(bus.out_data));
      n_words++;
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    end_busy  = bus.busy;
    end_crdy  = bus.cap_ready;
    end_valid = bus.out_valid;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if (bus.cap_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: cap_ready=%b out_valid=%b busy=%b, required 1 0 0",
               bus.cap_ready, bus.out_valid, bus.busy);
    end
    tests_run++;
    if (bus.out_idx !== 4'd0 || bus.out_data !== 8'd0 || bus.ovf_flag !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_data: out_idx=%0d out_data=%0d ovf=%b, required 0 0 0",
               bus.out_idx, bus.out_data, bus.ovf_flag);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_pass();
    for (int i = 0; i < X; i++) begin pe_v[i] = 16'(16 * i); exp_out[i] = i; end
    capture(1'b0, 1'b1);
    run_drain();
    tests_run++;
    if (n_words !== X) begin
      tests_failed++;
      $display("FAIL single_count: words=%0d, required %0d consecutive", n_words, X);
    end
    for (int i = 0; i < X && i < n_words; i++) begin
      tests_run++;
      if (obs_idx[i] !== i || obs_data[i] !== exp_out[i]) begin
        tests_failed++;
        $display("FAIL single_word%0d: idx=%0d data=%0d, required idx=%0d data=%0d",
                 i, obs_idx[i], obs_data[i], i, exp_out[i]);
      end
    end
    tests_run++;
    if (end_busy !== 1'b0 || end_crdy !== 1'b1 || end_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_idle: busy=%b cap_ready=%b out_valid=%b, required 0 1 0",
               end_busy, end_crdy, end_valid);
    end
  endtask

  task automatic test_multi_pass();
    for (int i = 0; i < X; i++) begin pe_v[i] = 16'sd100; exp_out[i] = 18; end
    capture(1'b0, 1'b0);
    tests_run++;
    if (bus.busy !== 1'b1 || bus.cap_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL accum_state: busy=%b cap_ready=%b out_valid=%b, required 1 1 0",
               bus.busy, bus.cap_ready, bus.out_valid);
    end
    capture(1'b1, 1'b0);
    capture(1'b1, 1'b1);
    run_drain();
    tests_run++;
    if (n_words !== X) begin
      tests_failed++;
      $display("FAIL multi_count: words=%0d, required %0d", n_words, X);
    end
    for (int i = 0; i < X && i < n_words; i++) begin
      tests_run++;
      if (obs_idx[i] !== i || obs_data[i] !== exp_out[i]) begin
        tests_failed++;
        $display("FAIL multi_word%0d: idx=%0d data=%0d, required idx=%0d data=%0d",
                 i, obs_idx[i], obs_data[i], i, exp_out[i]);
      end
    end
  endtask

  // Lanes still hold 300 from the previous tile; acc_mode=1 from IDLE must overwrite.
  task automatic test_idle_accmode();
    for (int i = 0; i < X; i++) begin pe_v[i] = -16'(16 * i); exp_out[i] = -i; end
`ifdef PSUM_DRAIN_RELU_EN
    for (int i = 0; i < X; i++) exp_out[i] = 0;
`endif
    capture(1'b1, 1'b1);
    run_drain();
    tests_run++;
    if (n_words !== X) begin
      tests_failed++;
      $display("FAIL idle_acc_count: words=%0d, required %0d", n_words, X);
    end
    for (int i = 0; i < X && i < n_words; i++) begin
      tests_run++;
      if (obs_data[i] !== exp_out[i]) begin
        tests_failed++;
        $display("FAIL idle_acc_word%0d: data=%0d, required %0d", i, obs_data[i], exp_out[i]);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < X; i++) begin pe_v[i] = 16'sd0; exp_out[i] = 0; end
    pe_v[3] = -16'sd320;  exp_out[3] = -20;
    pe_v[5] = -16'sd4096; exp_out[5] = -128;
    pe_v[6] = 16'sd2047;  exp_out[6] = 127;
    pe_v[7] = 16'sd2048;  exp_out[7] = 127;
    pe_v[8] = -16'sd2048; exp_out[8] = -128;
    pe_v[9] = -16'sd15;   exp_out[9] = -1;
`ifdef PSUM_DRAIN_RELU_EN
    exp_out[3] = 0; exp_out[5] = 0; exp_out[8] = 0; exp_out[9] = 0;
`endif
    capture(1'b0, 1'b1);
    run_drain();
    tests_run++;
    if (n_words !== X) begin
      tests_failed++;
      $display("FAIL sat_count: words=%0d, required %0d", n_words, X);
    end
    for (int i = 0; i < X && i < n_words; i++) begin
      tests_run++;
      if (obs_data[i] !== exp_out[i]) begin
        tests_failed++;
        $display("FAIL sat_word%0d: data=%0d, required %0d", i, obs_data[i], exp_out[i]);
      end
    end
  endtask

  // 32767*300 wraps 24 bits to -6947116 -> -128 after shift+saturation.
  task automatic test_overflow();
    pe_v[0] = 16'sd32767; exp_out[0] = -128;
`ifdef PSUM_DRAIN_RELU_EN
    exp_out[0] = 0;
`endif
    for (int i = 1; i < X; i++) begin pe_v[i] = 16'sd4095; exp_out[i] = 127; end
    capture(1'b0, 1'b0);
    tests_run++;
    if (bus.ovf_flag !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_first: ovf_flag=%b, required 0", bus.ovf_flag);
    end
    for (int n = 0; n < 298; n++) capture(1'b1, 1'b0);
    capture(1'b1, 1'b1);
    tests_run++;
    if (bus.ovf_flag !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set: ovf_flag=%b, required 1", bus.ovf_flag);
    end
    run_drain();
    for (int i = 0; i < X && i < n_words; i++) begin
      tests_run++;
      if (obs_data[i] !== exp_out[i]) begin
        tests_failed++;
        $display("FAIL ovf_word%0d: data=%0d, required %0d", i, obs_data[i], exp_out[i]);
      end
    end
    tests_run++;
    if (n_words !== X || bus.ovf_flag !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_sticky: words=%0d ovf_flag=%b, required %0d 1", n_words, bus.ovf_flag, X);
    end
    for (int i = 0; i < X; i++) pe_v[i] = 16'sd16;
    capture(1'b0, 1'b1);
    tests_run++;
    if (bus.ovf_flag !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clear: ovf_flag=%b, required 0", bus.ovf_flag);
    end
    run_drain();
  endtask

  // out_ready 1,0,0,1 repeating with a hostile capture held on the bus.
  task automatic test_stall();
    logic [3:0] pat;
    int idx = 0;
    int k   = 0;
    int got;
    pat = 4'b1001;
    for (int i = 0; i < X; i++) begin pe_v[i] = -16'(32 * i); exp_out[i] = -2 * i; end
`ifdef PSUM_DRAIN_RELU_EN
    for (int i = 0; i < X; i++) exp_out[i] = 0;
`endif
    capture(1'b0, 1'b1);
    for (int i = 0; i < X; i++) bus.pe_out[i] = 16'sd1600;
    bus.cap_valid = 1'b1;
    bus.acc_mode  = 1'b1;
    bus.last_pass = 1'b1;
    while (idx < X && k < 80) begin
      got = int'($signed(bus.out_data));
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== 4'(idx) || got !== exp_out[idx]
          || bus.cap_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_cyc%0d: valid=%b idx=%0d data=%0d cap_ready=%b, required 1 %0d %0d 0",
                 k, bus.out_valid, bus.out_idx, got, bus.cap_ready, idx, exp_out[idx]);
      end
      bus.out_ready = pat[3 - (k % 4)];
      @(negedge clk);
      if (bus.out_ready) idx++;
      k++;
    end
    bus.cap_valid = 1'b0;
    bus.acc_mode  = 1'b0;
    bus.last_pass = 1'b0;
    bus.out_ready = 1'b0;
    tests_run++;
    if (idx !== X || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_end: words=%0d out_valid=%b busy=%b, required %0d 0 0",
               idx, bus.out_valid, bus.busy, X);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_drain();
    int cyc = 0;
    for (int i = 0; i < X; i++) pe_v[i] = 16'(16 * i);
    capture(1'b0, 1'b1);
    bus.out_ready = 1'b1;
    while (bus.out_idx !== 4'd7 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (bus.out_idx !== 4'd7 || bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_reach7: idx=%0d valid=%b, required 7 1", bus.out_idx, bus.out_valid);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_idx !== 4'd0
        || bus.cap_ready !== 1'b1 || bus.out_data !== 8'd0) begin
      tests_failed++;
      $display("FAIL rst_async: valid=%b busy=%b idx=%0d cap_ready=%b data=%0d, required 0 0 0 1 0",
               bus.out_valid, bus.busy, bus.out_idx, bus.cap_ready, bus.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_quiet%0d: out_valid=%b, required 0", n, bus.out_valid);
      end
    end
    bus.out_ready = 1'b0;
    for (int i = 0; i < X; i++) begin pe_v[i] = 16'(48 * i); exp_out[i] = 3 * i; end
    capture(1'b0, 1'b1);
    run_drain();
    tests_run++;
    if (n_words !== X) begin
      tests_failed++;
      $display("FAIL rst_redrain_count: words=%0d, required %0d", n_words, X);
    end
    for (int i = 0; i < X && i < n_words; i++) begin
      tests_run++;
      if (obs_idx[i] !== i || obs_data[i] !== exp_out[i]) begin
        tests_failed++;
        $display("FAIL rst_redrain%0d: idx=%0d data=%0d, required idx=%0d data=%0d",
                 i, obs_idx[i], obs_data[i], i, exp_out[i]);
      end
    end
  endtask

  initial begin
    bus.cap_valid = 1'b0;
    bus.acc_mode  = 1'b0;
    bus.last_pass = 1'b0;
    bus.out_ready = 1'b0;
    bus.pe_out    = '0;
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_idle_accmode();
    test_saturation();
    test_overflow();
    test_stall();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
